// File: rtl/pic_host_bus_master.sv
// pic_host_bus_master: host-side initiator for the 8259A CPU bus.
// Define PIC_INIT_MASK_EN to append an OCW1 mask write to the init sequence.
module pic_host_bus_master #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       init_start,
  input  logic       init_ltim,
  input  logic       init_sngl,
  input  logic       init_ic4,
  input  logic [4:0] init_vector,
  input  logic [7:0] init_icw3,
  input  logic [4:0] init_icw4,
`ifdef PIC_INIT_MASK_EN
  input  logic [7:0] init_mask,
`endif
  output logic       init_busy,
  output logic       init_done,
  output logic       CS_bar,
  output logic       WR_bar,
  output logic       RD_bar,
  output logic       A0,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  input  logic [7:0] data_bus_in
);

  // counters load count-1; a zero parameter behaves as one cycle
  localparam logic [3:0] SETUP_LD =
    (SETUP_CYC <= 1) ? 4'd0 : 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD =
    (STROBE_CYC <= 1) ? 4'd0 : 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD =
    (HOLD_CYC <= 1) ? 4'd0 : 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOV_LD =
    (RECOVERY_CYC <= 1) ? 4'd0 : 4'(RECOVERY_CYC - 1);

`ifdef PIC_INIT_MASK_EN
  localparam logic MASK_Q = 1'b1;
  logic [7:0] mask_in;
  assign mask_in = init_mask;
`else
  localparam logic MASK_Q = 1'b0;
  logic [7:0] mask_in;
  assign mask_in = 8'h00;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RECOVER
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  // pending init writes: bit0 ICW1 .. bit3 ICW4, bit4 OCW1
  logic [4:0] q, q_n;
  logic       cur_wr, wr_n;
  logic       cur_init, init_n;
  logic       a0_n;
  logic [7:0] dout_n;
  logic       rsp_valid_n;
  logic [7:0] rsp_data_n;
  logic       done_n, busy_n, ready_n;
  logic       launch, start_init, accept;

  logic       cfg_ltim, cfg_sngl, cfg_ic4;
  logic [4:0] cfg_vec, cfg_icw4;
  logic [7:0] cfg_icw3, cfg_mask;

  // a new init request is ignored while one is outstanding;
  // it also blocks a command offered in the same cycle
  assign start_init = init_start && !init_busy;
  assign accept     = cmd_valid && cmd_ready && !init_start;

  // state register and phase counter
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state, access launch and registered-output next values
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    q_n         = q;
    wr_n        = cur_wr;
    init_n      = cur_init;
    a0_n        = A0;
    dout_n      = data_bus_out;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    done_n      = 1'b0;
    launch      = 1'b0;
    unique case (state)
      IDLE: launch = 1'b1;
      SETUP:
        if (cnt == 4'd0) begin
          state_n = STROBE;
          cnt_n   = STROBE_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      STROBE:
        if (cnt == 4'd0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
          if (!cur_wr && !cur_init) begin
            rsp_valid_n = 1'b1;
            rsp_data_n  = data_bus_in;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      HOLD:
        if (cnt == 4'd0) begin
          state_n = RECOVER;
          cnt_n   = RECOV_LD;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      RECOVER:
        if (cnt == 4'd0) begin
          state_n = IDLE;
          launch  = 1'b1;
          done_n  = cur_init && (q == 5'd0);
          init_n  = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      if (q != 5'd0) begin
        state_n = SETUP;
        cnt_n   = SETUP_LD;
        wr_n    = 1'b1;
        init_n  = 1'b1;
        a0_n    = 1'b1;
        priority case (1'b1)
          q[0]: begin
            a0_n   = 1'b0;
            dout_n = {3'b000, 1'b1, cfg_ltim,
                      1'b0, cfg_sngl, cfg_ic4};
            q_n[0] = 1'b0;
          end
          q[1]: begin
            dout_n = {cfg_vec, 3'b000};
            q_n[1] = 1'b0;
          end
          q[2]: begin
            dout_n = cfg_icw3;
            q_n[2] = 1'b0;
          end
          q[3]: begin
            dout_n = {3'b000, cfg_icw4};
            q_n[3] = 1'b0;
          end
          default: begin
            dout_n = cfg_mask;
            q_n[4] = 1'b0;
          end
        endcase
      end else if (accept) begin
        state_n = SETUP;
        cnt_n   = SETUP_LD;
        wr_n    = cmd_write;
        init_n  = 1'b0;
        a0_n    = cmd_a0;
        if (cmd_write) dout_n = cmd_data;
      end
    end
    if (start_init)
      q_n = {MASK_Q, init_ic4, ~init_sngl, 1'b1, 1'b1};
    busy_n  = (q_n != 5'd0) || (init_n && state_n != IDLE);
    ready_n = (state_n == IDLE) && !busy_n;
  end

  // queue, access context and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      q            <= 5'd0;
      cur_wr       <= 1'b0;
      cur_init     <= 1'b0;
      CS_bar       <= 1'b1;
      WR_bar       <= 1'b1;
      RD_bar       <= 1'b1;
      A0           <= 1'b0;
      data_bus_out <= 8'h00;
      data_bus_oe  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      init_busy    <= 1'b0;
      init_done    <= 1'b0;
      cmd_ready    <= 1'b0;
    end else begin
      q            <= q_n;
      cur_wr       <= wr_n;
      cur_init     <= init_n;
      CS_bar       <= !(state_n == SETUP || state_n == STROBE ||
                        state_n == HOLD);
      WR_bar       <= !(state_n == STROBE && wr_n);
      RD_bar       <= !(state_n == STROBE && !wr_n);
      A0           <= a0_n;
      data_bus_out <= dout_n;
      data_bus_oe  <= wr_n && (state_n == SETUP ||
                               state_n == STROBE || state_n == HOLD);
      rsp_valid    <= rsp_valid_n;
      rsp_data     <= rsp_data_n;
      init_busy    <= busy_n;
      init_done    <= done_n;
      cmd_ready    <= ready_n;
    end
  end

  // init configuration snapshot taken when a sequence is requested
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      cfg_ltim <= 1'b0;
      cfg_sngl <= 1'b0;
      cfg_ic4  <= 1'b0;
      cfg_vec  <= 5'd0;
      cfg_icw3 <= 8'h00;
      cfg_icw4 <= 5'd0;
      cfg_mask <= 8'h00;
    end else if (start_init) begin
      cfg_ltim <= init_ltim;
      cfg_sngl <= init_sngl;
      cfg_ic4  <= init_ic4;
      cfg_vec  <= init_vector;
      cfg_icw3 <= init_icw3;
      cfg_icw4 <= init_icw4;
      cfg_mask <= mask_in;
    end
  end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// tb_pic_host_bus_master: directed bench for the 8259A host bus master.
// Build with PIC_INIT_MASK_EN defined to cover the OCW1 mask write.
module tb_pic_host_bus_master;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_start, init_ltim, init_sngl, init_ic4;
  logic [4:0] init_vector, init_icw4;
  logic [7:0] init_icw3;
`ifdef PIC_INIT_MASK_EN
  logic [7:0] init_mask;
`endif
  logic       init_busy, init_done;
  logic       CS_bar, WR_bar, RD_bar, A0, data_bus_oe;
  logic [7:0] data_bus_out, data_bus_in;

  int checks = 0;
  int failures = 0;

  int         nw, done_cyc, done_cnt, rsp_cnt, acc_cyc;
  bit         overlap, busy_at_done, ready_busy;
  logic [8:0] wlog [8];
  int         wcyc [8];

  always #5 clk = ~clk;

  pic_host_bus_master dut (
    .clk(clk), .reset_bar(reset_bar),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_start(init_start), .init_ltim(init_ltim),
    .init_sngl(init_sngl), .init_ic4(init_ic4),
    .init_vector(init_vector), .init_icw3(init_icw3),
    .init_icw4(init_icw4),
`ifdef PIC_INIT_MASK_EN
    .init_mask(init_mask),
`endif
    .init_busy(init_busy), .init_done(init_done),
    .CS_bar(CS_bar), .WR_bar(WR_bar), .RD_bar(RD_bar), .A0(A0),
    .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
    .data_bus_in(data_bus_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // records bus activity for a fixed number of cycles
  task automatic watch(input int ncyc);
    logic prev_wr;
    bit   acc;
    prev_wr = 1'b1;
    nw = 0; done_cyc = -1; done_cnt = 0; rsp_cnt = 0;
    acc_cyc = -1; overlap = 0; busy_at_done = 0; ready_busy = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (!WR_bar && prev_wr && nw < 8) begin
        wlog[nw] = {A0, data_bus_out};
        wcyc[nw] = i;
        nw++;
      end
      prev_wr = WR_bar;
      if (!WR_bar && !RD_bar) overlap = 1;
      if (rsp_valid) rsp_cnt++;
      if (init_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = i;
        busy_at_done = init_busy;
      end
      if (init_busy && cmd_ready) ready_busy = 1;
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) begin
        cmd_valid = 1'b0;
        acc_cyc = i;
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    reset_bar = 1'b0;
    tick();
    tick();
    obs = {CS_bar, WR_bar, RD_bar, A0, data_bus_oe,
           rsp_valid, init_busy, init_done, cmd_ready};
    checks++;
    if (obs !== 9'b111000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=%b", obs, 9'b111000000);
    end
    checks++;
    if ({data_bus_out, rsp_data} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data got=%h want=0000",
               {data_bus_out, rsp_data});
    end
    reset_bar = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_write();
    // {CS_bar, WR_bar, RD_bar, oe, cmd_ready} for cycles 1..7
    logic [4:0] tbl [7] = '{5'b01110, 5'b00110, 5'b00110,
                            5'b01110, 5'b11100, 5'b11100, 5'b11101};
    logic [4:0] obs;
    cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'hAA;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      obs = {CS_bar, WR_bar, RD_bar, data_bus_oe, cmd_ready};
      checks++;
      if (obs !== tbl[c]) begin
        failures++;
        $display("FAIL write_c%0d got=%b want=%b", c + 1, obs, tbl[c]);
      end
      if (c < 4) begin
        checks++;
        if ({A0, data_bus_out} !== 9'h1AA) begin
          failures++;
          $display("FAIL write_addr_c%0d got=%h want=1aa",
                   c + 1, {A0, data_bus_out});
        end
      end
      if (c < 6) tick();
    end
  endtask

  task automatic test_read();
    logic [4:0] tbl [7] = '{5'b01100, 5'b01000, 5'b01000,
                            5'b01100, 5'b11100, 5'b11100, 5'b11101};
    logic [4:0] obs;
    cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h77;
    data_bus_in = 8'h5C;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      obs = {CS_bar, WR_bar, RD_bar, data_bus_oe, cmd_ready};
      checks++;
      if (obs !== tbl[c]) begin
        failures++;
        $display("FAIL read_c%0d got=%b want=%b", c + 1, obs, tbl[c]);
      end
      checks++;
      if (rsp_valid !== (c == 3)) begin
        failures++;
        $display("FAIL read_rsp_valid_c%0d got=%b want=%b",
                 c + 1, rsp_valid, (c == 3));
      end
      if (c < 4) begin
        checks++;
        if (A0 !== 1'b0) begin
          failures++;
          $display("FAIL read_a0_c%0d got=%b want=0", c + 1, A0);
        end
      end
      if (c == 3) begin
        checks++;
        if (rsp_data !== 8'h5C) begin
          failures++;
          $display("FAIL read_data got=%h want=5c", rsp_data);
        end
      end
      if (c < 6) tick();
    end
    data_bus_in = 8'h00;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_data} !== 9'h05C) begin
      failures++;
      $display("FAIL read_hold got=%h want=05c", {rsp_valid, rsp_data});
    end
  endtask

  task automatic test_init_icw4();
    logic [8:0] exp [5];
    int nexp;
    init_ltim = 1'b0; init_sngl = 1'b1; init_ic4 = 1'b1;
    init_vector = 5'b00100; init_icw3 = 8'hEE; init_icw4 = 5'b00001;
`ifdef PIC_INIT_MASK_EN
    init_mask = 8'hFB;
`endif
    exp[0] = 9'h013; exp[1] = 9'h120; exp[2] = 9'h101;
    nexp = 3;
`ifdef PIC_INIT_MASK_EN
    exp[3] = 9'h1FB;
    nexp = 4;
`endif
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    checks++;
    if ({init_busy, cmd_ready} !== 2'b10) begin
      failures++;
      $display("FAIL init1_busy_start got=%b want=10",
               {init_busy, cmd_ready});
    end
    watch(60);
    checks++;
    if (nw !== nexp) begin
      failures++;
      $display("FAIL init1_count got=%0d want=%0d", nw, nexp);
    end
    for (int k = 0; k < nexp; k++) begin
      checks++;
      if (wlog[k] !== exp[k]) begin
        failures++;
        $display("FAIL init1_w%0d got=%h want=%h", k, wlog[k], exp[k]);
      end
    end
    checks++;
    if (wcyc[1] - wcyc[0] !== 6) begin
      failures++;
      $display("FAIL init1_spacing got=%0d want=6", wcyc[1] - wcyc[0]);
    end
    checks++;
    if ({done_cnt == 1, busy_at_done, rsp_cnt == 0, overlap}
        !== 4'b1010) begin
      failures++;
      $display("FAIL init1_done got=%0d/%b/%0d/%b want=1/0/0/0",
               done_cnt, busy_at_done, rsp_cnt, overlap);
    end
    checks++;
    if ({init_busy, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL init1_end got=%b want=01", {init_busy, cmd_ready});
    end
  endtask

  task automatic test_init_icw3_cmd();
    logic [8:0] exp [6];
    int nexp;
    init_ltim = 1'b0; init_sngl = 1'b0; init_ic4 = 1'b0;
    init_vector = 5'b11111; init_icw3 = 8'h04; init_icw4 = 5'b10101;
`ifdef PIC_INIT_MASK_EN
    init_mask = 8'hFB;
`endif
    exp[0] = 9'h010; exp[1] = 9'h1F8; exp[2] = 9'h104;
    nexp = 3;
`ifdef PIC_INIT_MASK_EN
    exp[3] = 9'h1FB;
    nexp = 4;
`endif
    exp[nexp] = 9'h03C;
    cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h3C;
    cmd_valid = 1'b1;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    checks++;
    if ({init_busy, cmd_ready, CS_bar} !== 3'b101) begin
      failures++;
      $display("FAIL init2_start got=%b want=101",
               {init_busy, cmd_ready, CS_bar});
    end
    watch(70);
    checks++;
    if (nw !== nexp + 1) begin
      failures++;
      $display("FAIL init2_count got=%0d want=%0d", nw, nexp + 1);
    end
    for (int k = 0; k <= nexp; k++) begin
      checks++;
      if (wlog[k] !== exp[k]) begin
        failures++;
        $display("FAIL init2_w%0d got=%h want=%h", k, wlog[k], exp[k]);
      end
    end
    checks++;
    if (done_cnt != 1 || acc_cyc < done_cyc || ready_busy ||
        wcyc[nexp] <= done_cyc) begin
      failures++;
      $display("FAIL init2_order done=%0d@%0d acc=%0d cmdw=%0d rb=%b",
               done_cnt, done_cyc, acc_cyc, wcyc[nexp], ready_busy);
    end
    checks++;
    if (cmd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL init2_end got=%b%b want=01", cmd_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] obs;
    cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h81;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (WR_bar !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_strobe got=%b want=0", WR_bar);
    end
    reset_bar = 1'b0;
    tick();
    obs = {CS_bar, WR_bar, RD_bar, data_bus_oe,
           rsp_valid, init_done, cmd_ready};
    checks++;
    if (obs !== 7'b1110000) begin
      failures++;
      $display("FAIL rstmid_release got=%b want=1110000", obs);
    end
    reset_bar = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready got=%b want=1", cmd_ready);
    end
    // abort an init sequence part way through
    init_sngl = 1'b1; init_ic4 = 1'b1;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick();
    tick();
    tick();
    reset_bar = 1'b0;
    tick();
    reset_bar = 1'b1;
    watch(20);
    checks++;
    if (nw != 0 || done_cnt != 0 || rsp_cnt != 0 ||
        init_busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_init w=%0d done=%0d rsp=%0d busy=%b rdy=%b",
               nw, done_cnt, rsp_cnt, init_busy, cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_bar = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0;
    cmd_data = 8'h00; data_bus_in = 8'h00;
    init_start = 1'b0; init_ltim = 1'b0; init_sngl = 1'b0;
    init_ic4 = 1'b0; init_vector = 5'd0; init_icw3 = 8'h00;
    init_icw4 = 5'd0;
`ifdef PIC_INIT_MASK_EN
    init_mask = 8'h00;
`endif
    test_reset();
    test_write();
    test_read();
    test_init_icw4();
    test_init_icw3_cmd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
